// File: rtl/upg_loader.sv
`default_nettype none
// ============================================================================
// Module   : upg_loader
// Purpose  : UART-fed memory upgrade loader. Parses a frame
//              SEL, CNT_LO, CNT_HI, CNT*4 data bytes (little-endian words)
//            and emits one write pulse per assembled 32-bit word into the
//            instruction RAM (SEL=0x00) or data RAM (SEL=0x01).
// Option   : UPG_LOADER_CHECKSUM_EN -- when defined, one trailing byte must
//            equal the XOR of all data bytes for the frame to complete.
// Ports    : upg_clk_i   in   UPG clock, all state on rising edge
//            upg_rst_i   in   asynchronous active-high reset
//            rx_valid_i  in   one-cycle strobe, rx_data_i holds a byte
//            rx_data_i   in   [7:0] received byte
//            upg_wen_o   out  one-cycle write pulse per word
//            upg_adr_o   out  [14:0] bit14 target RAM, bits13:0 word index
//            upg_dat_o   out  [31:0] word to write
//            upg_done_o  out  sticky frame-complete flag
//            busy_o      out  frame in progress
//            err_o       out  sticky frame-aborted flag
// Revision : 1.0 - initial release
// ============================================================================
module upg_loader #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_WORDS      = 16384
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int              c_TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TO_ONE    = c_TW'(1);
  localparam logic [16:0]     c_MAX_WORDS = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNT_L = 3'd1,
    S_CNT_H = 3'd2,
    S_DATA  = 3'd3,
`ifdef UPG_LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t          r_state;
  logic            r_sel;
  logic [15:0]     r_cnt;
  logic [14:0]     r_widx;     // 15 bits so r_widx+1 can reach CNT without wrap
  logic [1:0]      r_bcnt;
  logic [23:0]     r_word;     // first three bytes of the current word
  logic            r_fin;      // last word pulsed; DONE follows one cycle later
  logic [c_TW-1:0] r_to;
  logic            r_wen;
  logic [14:0]     r_adr;
  logic [31:0]     r_dat;
  logic            r_done;
  logic            r_busy;
  logic            r_err;
`ifdef UPG_LOADER_CHECKSUM_EN
  logic [7:0]      r_xor;
`endif

  logic [15:0] w_cnt;
  logic        w_last;
  logic        w_to_hit;

  assign w_cnt    = {rx_data_i, r_cnt[7:0]};
  assign w_last   = (({1'b0, r_widx} + 16'd1) == r_cnt);
  // Counter would reach TIMEOUT_CYCLES on this edge with no byte arriving.
  assign w_to_hit = (r_to == c_TO_LAST) && !rx_valid_i;

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_cnt   <= 16'd0;
      r_widx  <= 15'd0;
      r_bcnt  <= 2'd0;
      r_word  <= 24'd0;
      r_fin   <= 1'b0;
      r_to    <= '0;
      r_wen   <= 1'b0;
      r_adr   <= 15'd0;
      r_dat   <= 32'd0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
`ifdef UPG_LOADER_CHECKSUM_EN
      r_xor   <= 8'd0;
`endif
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_to <= '0;
          if (rx_valid_i) begin
            if (rx_data_i == 8'h00 || rx_data_i == 8'h01) begin
              r_sel   <= rx_data_i[0];
              r_state <= S_CNT_L;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end

        S_CNT_L: begin
          if (rx_valid_i) begin
            r_to       <= '0;
            r_cnt[7:0] <= rx_data_i;
            r_state    <= S_CNT_H;
          end else if (w_to_hit) begin
            r_to    <= '0;
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_to <= r_to + c_TO_ONE;
          end
        end

        S_CNT_H: begin
          if (rx_valid_i) begin
            r_to   <= '0;
            r_cnt  <= w_cnt;
            r_widx <= 15'd0;
            r_bcnt <= 2'd0;
            if (w_cnt == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if ({1'b0, w_cnt} > c_MAX_WORDS) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else if (w_to_hit) begin
            r_to    <= '0;
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_to <= r_to + c_TO_ONE;
          end
        end

        S_DATA: begin
          if (r_fin) begin
            // Final write pulse is on the outputs this cycle.
            r_fin   <= 1'b0;
            r_to    <= '0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (rx_valid_i) begin
            r_to   <= '0;
            r_bcnt <= r_bcnt + 2'd1;
`ifdef UPG_LOADER_CHECKSUM_EN
            r_xor  <= r_xor ^ rx_data_i;
`endif
            if (r_bcnt == 2'd3) begin
              r_wen  <= 1'b1;
              r_dat  <= {rx_data_i, r_word};
              r_adr  <= {r_sel, r_widx[13:0]};
              r_widx <= r_widx + 15'd1;
              if (w_last) begin
`ifdef UPG_LOADER_CHECKSUM_EN
                r_state <= S_CHK;
`else
                r_fin   <= 1'b1;
`endif
              end
            end else begin
              // Shift right so the first byte lands in bits 7:0.
              r_word <= {rx_data_i, r_word[23:8]};
            end
          end else if (w_to_hit) begin
            r_to    <= '0;
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_to <= r_to + c_TO_ONE;
          end
        end

`ifdef UPG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid_i) begin
            r_to   <= '0;
            r_busy <= 1'b0;
            if (rx_data_i == r_xor) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end else if (w_to_hit) begin
            r_to    <= '0;
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_to <= r_to + c_TO_ONE;
          end
        end
`endif

        S_DONE: r_to <= '0;
        S_ERR:  r_to <= '0;

        default: begin
          r_state <= S_ERR;
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_to    <= '0;
        end
      endcase
    end
  end

  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = r_done;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_upg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_upg_loader
// Purpose  : Self-checking bench for upg_loader. Directed frames plus random
//            frames checked against a frame-level reference model.
//            Honours UPG_LOADER_CHECKSUM_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upg_loader;

  localparam int TO   = 16;
  localparam int MAXW = 6;
`ifdef UPG_LOADER_CHECKSUM_EN
  localparam int CHKB = 1;
`else
  localparam int CHKB = 0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wen;
  logic [14:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [46:0] got_q[$];
  logic [46:0] exp_q[$];
  bit          e_done, e_err;
  bit          both_seen = 1'b0;

  upg_loader #(.TIMEOUT_CYCLES(TO), .MAX_WORDS(MAXW)) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (wen) got_q.push_back({adr, dat});
    if (done && err) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    got_q.delete();
    both_seen = 1'b0;
    rst = 1'b0;
  endtask

  // Called at #1 after an edge; returns at #1 after the edge that took the byte.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Frame-level reference: which words get written and how the frame ends,
  // given the frame bytes and how many of them were actually delivered.
  function automatic void model(input bq_t fr, input int n);
    int cnt;
    logic [7:0] x;
    logic [14:0] a;
    exp_q.delete();
    e_done = 1'b0;
    e_err  = 1'b0;
    if (fr[0] > 8'd1 || n < 3) begin e_err = 1'b1; return; end
    cnt = {fr[2], fr[1]};
    if (cnt == 0) begin e_done = 1'b1; return; end
    if (cnt > MAXW) begin e_err = 1'b1; return; end
    x = 8'h00;
    for (int w = 0; w < cnt; w++) begin
      if (3 + 4*w + 3 < n) begin
        a = 15'(w);
        a[14] = fr[0][0];
        exp_q.push_back({a, fr[3+4*w+3], fr[3+4*w+2], fr[3+4*w+1], fr[3+4*w]});
      end
    end
    for (int i = 3; i < 3 + 4*cnt && i < fr.size(); i++) x ^= fr[i];
    if (n < 3 + 4*cnt + CHKB) e_err = 1'b1;
`ifdef UPG_LOADER_CHECKSUM_EN
    else if (fr[3+4*cnt] == x) e_done = 1'b1;
    else e_err = 1'b1;
`else
    else e_done = 1'b1;
`endif
  endfunction

  function automatic logic [7:0] xsum(input bq_t fr, input int cnt);
    logic [7:0] x = 8'h00;
    for (int i = 3; i < 3 + 4*cnt; i++) x ^= fr[i];
    return x;
  endfunction

  task automatic compare_result(input string tag);
    chk({tag, " nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, " wr"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, " done"}, 64'(done), 64'(e_done));
    chk({tag, " err"}, 64'(err), 64'(e_err));
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " both"}, 64'(both_seen), 64'd0);
  endtask

  task automatic run_frame(input bq_t fr, input int n, input bit nogap, input string tag);
    do_reset();
    model(fr, n);
    for (int i = 0; i < n; i++) begin
      if (!nogap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(fr[i]);
    end
    idle(TO + 4);
    compare_result(tag);
  endtask

  initial begin
    bq_t fr;
    int  cnt, len, n;

    // Reset state
    @(posedge clk); #1;
    chk("reset outs", 64'({wen, adr, dat, done, busy, err}), 64'd0);
    rst = 1'b0;

    // Single word to instruction RAM, exact pulse and done timing
    do_reset();
    send(8'h00); send(8'h01); send(8'h00);
    chk("busy in frame", 64'(busy), 64'd1);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("w1 wen", 64'(wen), 64'd1);
    chk("w1 adr", 64'(adr), 64'h0000);
    chk("w1 dat", 64'(dat), 64'h12345678);
    chk("w1 done early", 64'(done), 64'd0);
`ifdef UPG_LOADER_CHECKSUM_EN
    send(8'h08);
`else
    idle(1);
`endif
    chk("w1 wen low", 64'(wen), 64'd0);
    chk("w1 done", 64'(done), 64'd1);
    chk("w1 busy", 64'(busy), 64'd0);
    send(8'h00); send(8'h01);
    chk("done ignores rx", 64'(got_q.size()), 64'd1);

    // Two words to data RAM, back-to-back bytes
    fr = '{8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    if (CHKB == 1) fr.push_back(xsum(fr, 2));
    run_frame(fr, fr.size(), 1'b1, "dram b2b");

    // Bad SEL: error next cycle, later bytes ignored
    do_reset();
    send(8'h05);
    chk("badsel err", 64'(err), 64'd1);
    chk("badsel done", 64'(done), 64'd0);
    send(8'h00); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);
    chk("badsel nwr", 64'(got_q.size()), 64'd0);
    chk("badsel err hold", 64'(err), 64'd1);

    // Timeout after two data bytes: exactly TO idle cycles
    do_reset();
    send(8'h00); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    idle(TO - 1);
    chk("to early err", 64'(err), 64'd0);
    chk("to early busy", 64'(busy), 64'd1);
    idle(1);
    chk("to err", 64'(err), 64'd1);
    chk("to busy", 64'(busy), 64'd0);

    // Reset mid-word, then a full single-word frame
    do_reset();
    send(8'h00); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst outs", 64'({wen, adr, dat, done, busy, err}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    fr = '{8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CHKB == 1) fr.push_back(xsum(fr, 1));
    model(fr, fr.size());
    foreach (fr[i]) send(fr[i]);
    idle(3);
    compare_result("rst midword");

    // Reset during a write pulse
    do_reset();
    send(8'h01); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    rst = 1'b1;
    #1;
    chk("rst on wen", 64'({wen, adr, dat, done, busy, err}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Count boundaries: zero, MAX and MAX+1
    run_frame('{8'h00, 8'h00, 8'h00}, 3, 1'b1, "cnt0");
    fr = '{8'h01, 8'(MAXW + 1), 8'h00, 8'h01, 8'h02};
    run_frame(fr, fr.size(), 1'b1, "cnt max+1");
    fr = '{8'h00, 8'(MAXW), 8'h00};
    for (int i = 0; i < 4*MAXW; i++) fr.push_back(8'($urandom_range(0, 255)));
    if (CHKB == 1) fr.push_back(xsum(fr, MAXW));
    run_frame(fr, fr.size(), 1'b0, "cnt max");

`ifdef UPG_LOADER_CHECKSUM_EN
    run_frame('{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}, 8, 1'b1, "chk good");
    run_frame('{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00}, 8, 1'b1, "chk bad");
`endif

    // Random frames
    for (int t = 0; t < 40; t++) begin
      fr.delete();
      if ($urandom_range(0, 9) == 0) fr.push_back(8'($urandom_range(2, 255)));
      else fr.push_back(8'($urandom_range(0, 1)));
      cnt = $urandom_range(0, MAXW + 1);
      fr.push_back(8'(cnt));
      fr.push_back(8'h00);
      if (cnt <= MAXW) begin
        for (int i = 0; i < 4*cnt; i++) fr.push_back(8'($urandom_range(0, 255)));
        if (CHKB == 1 && cnt > 0) begin
          if ($urandom_range(0, 3) == 0) fr.push_back(8'($urandom_range(0, 255)));
          else fr.push_back(xsum(fr, cnt));
        end
      end
      len = fr.size();
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : len;
      run_frame(fr, n, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/upg_loader.md
UPG_LOADER -- requirements
Module: upg_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, upg_clk_i cycles without a received byte, mid-frame, before the frame is aborted.
REQ-002 Parameter MAX_WORDS, default 16384, largest legal word count per frame (14-bit word address space).
REQ-003 upg_clk_i  input  1  UPG clock (10 MHz); all state updates on its rising edge.
REQ-004 upg_rst_i  input  1  UPG reset; asynchronous, active-high.
REQ-005 rx_valid_i  input  1  one-cycle strobe: rx_data_i holds a received UART byte.
REQ-006 rx_data_i  input  8  received byte.
REQ-007 upg_wen_o  output  1  memory write enable, one-cycle pulse per word.
REQ-008 upg_adr_o  output  15  bit 14 = target (0 instruction RAM, 1 data RAM); bits 13:0 = word address.
REQ-009 upg_dat_o  output  32  word to write.
REQ-010 upg_done_o  output  1  high once a frame completes successfully; sticky until reset.
REQ-011 busy_o  output  1  high in any state other than IDLE, DONE or ERR.
REQ-012 err_o  output  1  high once a frame is aborted; sticky until reset.

Function
REQ-013 Frame format: SEL byte, CNT_LO byte, CNT_HI byte, then CNT*4 data bytes, each word little-endian (first byte -> bits 7:0).
REQ-014 States and transitions:
- IDLE -> CNT_L on a byte.
- CNT_L -> CNT_H on a byte.
- CNT_H -> DATA on a byte.
- DATA -> DONE after the last byte (or CHK when configured).
- Any state may go to ERR; DONE and ERR are terminal.
REQ-015 SEL value: 0x00 targets instruction RAM; 0x01 targets data RAM; any other value moves to ERR.
REQ-016 CNT = 0 moves directly from CNT_H to DONE with no writes; CNT > MAX_WORDS moves to ERR.
REQ-017 Upon acceptance of the 4th byte of a word, upg_wen_o SHALL pulse high for exactly the next cycle, with upg_dat_o = assembled word and upg_adr_o[13:0] = word index (first word 0).
REQ-018 Word index increments by one after each pulse; upg_adr_o and upg_dat_o hold their values between pulses.
REQ-019 A byte arriving in the same cycle as a wen pulse SHALL be accepted into the next word without loss (back-to-back rx_valid_i every cycle supported).
REQ-020 upg_done_o rises in the cycle after the final write pulse (or after CHK acceptance); it is never high together with err_o.
REQ-021 Timeout counter: cleared on every accepted byte and held at 0 in IDLE/DONE/ERR; reaching TIMEOUT_CYCLES in CNT_L, CNT_H, DATA or CHK moves to ERR.
REQ-022 In DONE and ERR, rx_valid_i is ignored; upg_wen_o stays 0.
REQ-023 Bytes are counted with a 2-bit byte counter; the word counter is 15 bits wide to compare against CNT without overflow.

Reset
REQ-024 Asserting upg_rst_i at any time, including mid-frame or during a wen pulse, SHALL immediately force IDLE, with all outputs and counters set to 0.
REQ-025 After release, the first accepted byte is interpreted as SEL.

Configuration
REQ-026 Macro UPG_LOADER_CHECKSUM_EN:
- Defined: after the last data byte the block enters CHK and takes one byte. If it equals the XOR of all data bytes -> DONE; otherwise -> ERR. Words already written are not retracted.
- Undefined: CHK state and XOR logic are absent; DATA goes directly to DONE.

Verification
REQ-027 SEL=00, CNT=0001, bytes 78 56 34 12 -> one wen pulse, adr=0x0000, dat=0x12345678; done_o=1 one cycle later.
REQ-028 SEL=01, CNT=0002, 8 bytes on consecutive cycles -> two wen pulses, adr 0x4000 then 0x4001; no byte lost.
REQ-029 SEL=05 -> err_o=1 next cycle, no wen, done_o=0; subsequent bytes ignored.
REQ-030 TIMEOUT_CYCLES=16, frame stalls after 2 data bytes -> err_o=1 after 16 idle cycles, busy_o=0.
REQ-031 upg_rst_i asserted mid-word, then a full CNT=1 frame -> exactly one write at adr 0x0000 with the new data.
REQ-032 With UPG_LOADER_CHECKSUM_EN: frame bytes 01 02 03 04 with checksum 04 -> done_o=1; checksum 00 -> err_o=1, with the word still written once.
